// File: rtl/mem_stage_if.sv
// Data-cache request bus between the MEM stage (master) and the dcache (slave).
interface mem_stage_if #(
    parameter int unsigned XLEN = 64
);
    logic            dc_req_valid;
    logic            dc_req_ready;
    logic [XLEN-1:0] dc_addr;
    logic            dc_wen;
    logic [XLEN-1:0] dc_wdata;
    logic [7:0]      dc_wmask;
    logic [1:0]      dc_size;

    modport master (
        output dc_req_valid, dc_addr, dc_wen, dc_wdata, dc_wmask, dc_size,
        input  dc_req_ready
    );

    modport slave (
        input  dc_req_valid, dc_addr, dc_wen, dc_wdata, dc_wmask, dc_size,
        output dc_req_ready
    );
endinterface

// File: rtl/mem_stage.sv
// EX->MEM->WB pipeline stage: issues dcache load/store requests and forwards payload to WB.
// Optional MEM_PERF_CNT_EN adds load/store/stall performance counters.
module mem_stage #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned ILEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            mem_allowin,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [ILEN-1:0] ex_inst,
    input  logic [XLEN-1:0] ex_ALUres,
    input  logic [XLEN-1:0] ex_R_rs2,
    input  logic [XLEN-1:0] ex_R_rs1,
    input  logic            ex_MemRd,
    input  logic            ex_MemWr,
    input  logic [2:0]      ex_MemOP,
    input  logic [1:0]      ex_Wdata_src,
    input  logic            ex_RegWr,
    input  logic            ex_IntrEn,
    mem_stage_if.master     dc,
    output logic            wb_valid,
    input  logic            wb_allowin,
    output logic [XLEN-1:0] wb_pc,
    output logic [ILEN-1:0] wb_inst,
    output logic [XLEN-1:0] wb_ALUres,
    output logic [XLEN-1:0] wb_R_rs1,
    output logic [2:0]      wb_MemOP,
    output logic [1:0]      wb_Wdata_src,
    output logic            wb_RegWr,
    output logic            wb_IntrEn,
    output logic            mem_misalign
`ifdef MEM_PERF_CNT_EN
    ,
    output logic [63:0]     perf_ld_cnt,
    output logic [63:0]     perf_st_cnt,
    output logic [63:0]     perf_stall_cnt
`endif
);

    logic            m_valid;
    logic [XLEN-1:0] m_pc;
    logic [ILEN-1:0] m_inst;
    logic [XLEN-1:0] m_alures;
    logic [XLEN-1:0] m_rs2;
    logic [XLEN-1:0] m_rs1;
    logic            m_memrd;
    logic            m_memwr;
    logic [2:0]      m_memop;
    logic [1:0]      m_wdata_src;
    logic            m_regwr;
    logic            m_intren;

    logic       is_mem;
    logic       addr_off;
    logic       misalign;
    logic       mem_ready_go;
    logic       transfer;
    logic [7:0] size_mask;

    always_comb begin
        addr_off  = 1'b0;
        size_mask = 8'h00;
        unique case (m_memop[1:0])
            2'd0: begin addr_off = |m_alures[2:0]; size_mask = 8'hFF; end
            2'd1: begin addr_off = |m_alures[1:0]; size_mask = 8'h0F; end
            2'd2: begin addr_off = m_alures[0];    size_mask = 8'h03; end
            2'd3: begin addr_off = 1'b0;           size_mask = 8'h01; end
        endcase
    end

    assign is_mem       = m_memrd | m_memwr;
    assign misalign     = is_mem & addr_off;
    assign mem_ready_go = ~is_mem | misalign | dc.dc_req_ready;
    assign transfer     = m_valid & mem_ready_go & wb_allowin;
    assign mem_allowin  = ~m_valid | (mem_ready_go & wb_allowin);
    assign mem_misalign = transfer & misalign;

    // Requests only go out when WB can take the instruction in the same cycle,
    // so dcache acceptance and the MEM->WB transfer always coincide.
    assign dc.dc_req_valid = m_valid & is_mem & ~misalign & wb_allowin;
    assign dc.dc_addr      = m_alures;
    assign dc.dc_wen       = m_memwr;
    assign dc.dc_wdata     = m_rs2 << {m_alures[2:0], 3'b000};
    assign dc.dc_wmask     = m_memwr ? (size_mask << m_alures[2:0]) : '0;
    assign dc.dc_size      = m_memop[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid     <= 1'b0;
            m_pc        <= '0;
            m_inst      <= '0;
            m_alures    <= '0;
            m_rs2       <= '0;
            m_rs1       <= '0;
            m_memrd     <= 1'b0;
            m_memwr     <= 1'b0;
            m_memop     <= '0;
            m_wdata_src <= '0;
            m_regwr     <= 1'b0;
            m_intren    <= 1'b0;
        end else if (mem_allowin) begin
            m_valid <= ex_valid;
            if (ex_valid) begin
                m_pc        <= ex_pc;
                m_inst      <= ex_inst;
                m_alures    <= ex_ALUres;
                m_rs2       <= ex_R_rs2;
                m_rs1       <= ex_R_rs1;
                m_memrd     <= ex_MemRd;
                m_memwr     <= ex_MemWr;
                m_memop     <= ex_MemOP;
                m_wdata_src <= ex_Wdata_src;
                m_regwr     <= ex_RegWr;
                m_intren    <= ex_IntrEn;
            end
        end
    end

    // A dropped misaligned load gets no dcache response, so WB must not wait for one.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_pc        <= '0;
            wb_inst      <= '0;
            wb_ALUres    <= '0;
            wb_R_rs1     <= '0;
            wb_MemOP     <= '0;
            wb_Wdata_src <= '0;
            wb_RegWr     <= 1'b0;
            wb_IntrEn    <= 1'b0;
        end else if (transfer) begin
            wb_valid     <= 1'b1;
            wb_pc        <= m_pc;
            wb_inst      <= m_inst;
            wb_ALUres    <= m_alures;
            wb_R_rs1     <= m_rs1;
            wb_MemOP     <= (m_memrd & ~misalign) ? m_memop : 3'b000;
            wb_Wdata_src <= m_wdata_src;
            wb_RegWr     <= m_regwr & ~misalign;
            wb_IntrEn    <= m_intren;
        end else if (wb_allowin) begin
            wb_valid <= 1'b0;
        end
    end

`ifdef MEM_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ld_cnt    <= '0;
            perf_st_cnt    <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (dc.dc_req_valid & dc.dc_req_ready & m_memrd)
                perf_ld_cnt <= perf_ld_cnt + 64'd1;
            if (dc.dc_req_valid & dc.dc_req_ready & m_memwr)
                perf_st_cnt <= perf_st_cnt + 64'd1;
            if (dc.dc_req_valid & ~dc.dc_req_ready)
                perf_stall_cnt <= perf_stall_cnt + 64'd1;
        end
    end
`endif

endmodule
